instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage of the rv32i core, directly upstream of the instruction memory and downstream-feeding the decode stage. Owns the program counter, drives the instruction-memory address, captures the returned instruction word together with its PC into a small prefetch FIFO, and presents fetched instructions to decode with a valid/ready handshake. Handles control-flow redirects from execute by flushing the FIFO and reloading the PC.

## Interface

Parameters:
- NUM_INSTR, 32, number of instruction words in instruction memory; address width ADDR_W = $clog2(NUM_INSTR)*4, same as the instruction memory interface
- RESET_ADDR, 0, PC value loaded on reset (ADDR_W bits, word-aligned)
- FIFO_DEPTH, 2, prefetch FIFO entries; power of two, 2..8

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_addr  output  ADDR_W  byte address to instruction memory (datapath side of instr_memory_if)
- imem_instr  input  InstructionSize (32)  instruction word; combinational read of imem_addr, same cycle
- redirect  input  1  execute requests PC change (taken branch/jump)
- redirect_target  input  ADDR_W  new PC when redirect=1
- out_valid  output  1  out_instr/out_pc hold a fetched instruction
- out_ready  input  1  decode accepts; transfer when out_valid && out_ready
- out_instr  output  32  instruction word at FIFO head
- out_pc  output  ADDR_W  PC of out_instr
- fetch_fault  output  1  sticky misaligned-target flag (only with FETCH_ALIGN_CHECK_EN, else constant 0)

## Operation

- State: pc register (ADDR_W), FIFO of {pc, instr} entries, read/write pointers with one extra wrap bit, count.
- imem_addr = pc, driven combinationally from the register.
- Fetch: each cycle with redirect=0 and push_ok = (!full || pop), write {pc, imem_instr} at write pointer, pc <= pc + 4.
- pc arithmetic modulo 2^ADDR_W: pc at max aligned address wraps to 0, no flag.
- Pop: when out_valid && out_ready, advance read pointer.
- Push and pop in same cycle: count unchanged; allowed when full.
- full: no fetch, pc holds; imem_addr stable.
- out_valid = !empty; out_instr/out_pc = head entry (registered storage, no combinational path from imem_instr).
- Redirect (highest priority): FIFO emptied, pc <= redirect_target, no push that cycle. Any handshake in the redirect cycle is discarded (decode treats it as wrong-path).
- Consecutive redirects: last one wins; no push while redirect=1.

## Timing

- Reset (async assert): pc=RESET_ADDR, FIFO empty, out_valid=0, out_instr=0, out_pc=0, fetch_fault=0; imem_addr=RESET_ADDR.
- First cycle after reset deasserts: fetch RESET_ADDR; out_valid=1 next cycle with out_pc=RESET_ADDR.
- Fetch-to-output latency: 1 cycle. Sustained throughput: 1 instr/cycle with out_ready held high.
- Redirect asserted in cycle N: cycle N+1 imem_addr=target and push; cycle N+2 out_valid=1, out_pc=target. out_valid=0 in cycle N+1.
- Stall (out_ready=0): FIFO fills in FIFO_DEPTH cycles, then pc freezes; resumption refills without skipping or duplicating PCs.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries lost.

## Configuration

- FETCH_ALIGN_CHECK_EN defined: redirect_target[1:0] != 0 sets fetch_fault (sticky until rst), FIFO flushed, fetch halts (pc holds, no pushes, out_valid=0) until reset.
- Not defined: target low two bits forced to 0 on load; fetch_fault tied 0.

## Test plan

- Reset release, out_ready=1, memory word k = 0x1000_0000+k -> out_pc 0,4,8,... one per cycle from cycle 1, out_instr matches, fetch runs through and wraps at 2^ADDR_W to 0.
- out_ready=0 for 6 cycles after reset (FIFO_DEPTH=2) -> out_valid=1, out_pc=0 held, imem_addr freezes at 8; release -> sequence 0,4,8,12 with no gaps or duplicates.
- Redirect to 0x40 in cycle with full FIFO and out_ready=1 -> handshake discarded, out_valid=0 next cycle, out_pc=0x40 two cycles after redirect.
- Redirect on two consecutive cycles (0x20 then 0x30) -> only 0x30 stream appears, no 0x20 entry.
- Async rst asserted mid-stream -> out_valid drops without clock edge, imem_addr=RESET_ADDR; resumes from RESET_ADDR.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x22 -> fetch_fault=1 next cycle, out_valid stays 0; without macro -> fetch resumes at 0x20.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory, redirect and decode-side handshake signals of the fetch stage.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              fetch_fault;
  modport slave (
    output imem_addr, out_valid, out_instr, out_pc, fetch_fault,
    input  imem_instr, redirect, redirect_target, out_ready
  );
  modport master (
    input  imem_addr, out_valid, out_instr, out_pc, fetch_fault,
    output imem_instr, redirect, redirect_target, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register plus prefetch FIFO of {pc, instr} feeding decode; redirects flush and reload.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect target raises sticky fetch_fault and halts fetch.
module instr_fetch_unit #(
  parameter int               NUM_INSTR  = 32,
  parameter int               ADDR_W     = $clog2(NUM_INSTR)*4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [ADDR_W-1:0] pc_q, pc_d, tgt;
  logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0] pc_mem [FIFO_DEPTH];
  logic [31:0]       ins_mem [FIFO_DEPTH];
  logic              empty, full, pop, push, halt;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q ^ rd_q) == {1'b1, {PW{1'b0}}};
  assign pop   = !empty && bus.out_ready;
  assign push  = !bus.redirect && !halt && (!full || pop);
`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  assign tgt  = bus.redirect_target;
  // a misaligned target halts fetch in the very cycle it arrives, not one later
  assign halt = fault_q || (bus.redirect && bus.redirect_target[1:0] != 2'b00);
  assign bus.fetch_fault = fault_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) fault_q <= 1'b0;
    else     fault_q <= halt;
`else
  assign tgt  = bus.redirect_target & ~ADDR_W'(3);
  assign halt = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif
  always_comb begin
    pc_d = (bus.redirect && !halt) ? tgt : push ? pc_q + ADDR_W'(4) : pc_q;
    wr_d = bus.redirect ? '0 : wr_q + (PW+1)'(push);
    rd_d = bus.redirect ? '0 : rd_q + (PW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= RESET_ADDR;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      pc_q <= pc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_mem[wr_q[PW-1:0]]  <= pc_q;
      ins_mem[wr_q[PW-1:0]] <= bus.imem_instr;
    end
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = !empty;
  assign bus.out_pc    = empty ? '0 : pc_mem[rd_q[PW-1:0]];
  assign bus.out_instr = empty ? '0 : ins_mem[rd_q[PW-1:0]];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus random traffic checked every cycle against a queue-based fetch model.
module tb_instr_fetch_unit;
  localparam int NI = 32;
  localparam int AW = $clog2(NI)*4;
  localparam int D  = 2;
  typedef struct { logic [AW-1:0] pc; logic [31:0] ins; } ent_t;
  logic clk = 0;
  logic rst = 0;
  int vec = 0;
  int err = 0;
  ent_t q[$];
  logic [AW-1:0] mpc = '0;
  bit mfault = 0;
  logic [AW-1:0] maxa;
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.ADDR_W(AW)) bus();
  instr_fetch_unit #(.NUM_INSTR(NI), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  assign bus.imem_instr = 32'h1000_0000 + 32'(bus.imem_addr >> 2);
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      mpc = '0;
      mfault = 0;
    end else if (bus.redirect) begin
      q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.redirect_target[1:0] != 2'b00) mfault = 1;
      else if (!mfault) mpc = bus.redirect_target;
`else
      mpc = {bus.redirect_target[AW-1:2], 2'b00};
`endif
    end else begin
      if (q.size() > 0 && bus.out_ready) q.delete(0);
      if (!mfault && q.size() < D) begin
        q.push_back('{mpc, 32'h1000_0000 + 32'(mpc >> 2)});
        mpc = mpc + AW'(4);
      end
    end
  always @(negedge clk) begin
    check("out_valid", bus.out_valid, q.size() != 0);
    check("imem_addr", bus.imem_addr, mpc);
    check("fetch_fault", bus.fetch_fault, mfault);
    if (q.size() != 0) begin
      check("out_pc", bus.out_pc, q[0].pc);
      check("out_instr", bus.out_instr, q[0].ins);
    end
  end
  initial begin
    maxa = {AW{1'b1}};
    maxa[1:0] = 2'b00;
    bus.redirect = 0;
    bus.redirect_target = '0;
    bus.out_ready = 1;
    #1 rst = 1;
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_pc", bus.out_pc, 0);
    check("rst_instr", bus.out_instr, 0);
    check("rst_fault", bus.fetch_fault, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    repeat (2) @(negedge clk);
    check("first_pc", bus.out_pc, 0);
    check("first_instr", bus.out_instr, 32'h1000_0000);
    check("first_addr", bus.imem_addr, 4);
    @(negedge clk);
    check("second_pc", bus.out_pc, 4);
    #2 rst = 1;
    #1;
    check("async_valid", bus.out_valid, 0);
    check("async_addr", bus.imem_addr, 0);
    bus.out_ready = 0;
    @(posedge clk);
    #2 rst = 0;
    repeat (6) @(negedge clk);
    check("stall_valid", bus.out_valid, 1);
    check("stall_pc", bus.out_pc, 0);
    check("stall_addr", bus.imem_addr, 8);
    #2 bus.out_ready = 1;
    @(negedge clk); check("resume_pc4", bus.out_pc, 4);
    @(negedge clk); check("resume_pc8", bus.out_pc, 8);
    @(negedge clk); check("resume_pc12", bus.out_pc, 12);
    #2 begin bus.redirect = 1; bus.redirect_target = AW'(32'h40); end
    @(posedge clk);
    #2 bus.redirect = 0;
    @(negedge clk);
    check("redir_valid", bus.out_valid, 0);
    check("redir_addr", bus.imem_addr, 32'h40);
    @(negedge clk);
    check("redir_pc", bus.out_pc, 32'h40);
    #2 begin bus.redirect = 1; bus.redirect_target = AW'(32'h20); end
    @(posedge clk);
    #2 bus.redirect_target = AW'(32'h30);
    @(posedge clk);
    #2 bus.redirect = 0;
    @(negedge clk);
    check("dbl_valid", bus.out_valid, 0);
    check("dbl_addr", bus.imem_addr, 32'h30);
    @(negedge clk);
    check("dbl_pc", bus.out_pc, 32'h30);
    #2 begin bus.redirect = 1; bus.redirect_target = maxa; end
    @(posedge clk);
    #2 bus.redirect = 0;
    repeat (2) @(negedge clk);
    check("wrap_max", bus.out_pc, maxa);
    @(negedge clk);
    check("wrap_zero", bus.out_pc, 0);
    #2 begin bus.redirect = 1; bus.redirect_target = AW'(32'h22); end
    @(posedge clk);
    #2 bus.redirect = 0;
    @(negedge clk);
    check("mis_valid", bus.out_valid, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_fault", bus.fetch_fault, 1);
    @(negedge clk);
    check("mis_halt", bus.out_valid, 0);
`else
    check("mis_addr", bus.imem_addr, 32'h20);
    @(negedge clk);
    check("mis_pc", bus.out_pc, 32'h20);
`endif
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #2 rst = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      rst = ($urandom % 64) == 0;
      bus.out_ready = ($urandom % 4) != 0;
      bus.redirect = ($urandom % 12) == 0;
      bus.redirect_target = AW'($urandom);
      if ($urandom % 8 != 0) bus.redirect_target[1:0] = 2'b00;
      if ($urandom % 10 == 0) bus.redirect_target = maxa - AW'(4 * ($urandom % 3));
    end
    @(posedge clk);
    #2 begin rst = 0; bus.redirect = 0; end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
